uart_rx_ctrl_fsm: RTL
=====================

Name: uart_rx_ctrl_fsm

Overview:
Receive-side sequencer for the UART RX path.
- Detects the start-bit falling edge on the serial line.
- Enables and steers the edge/bit counter.
- Pulses enables for the start, data, parity and stop checkers and the deserializer at the mid-bit sample point.
- Qualifies the frame, then emits a one-cycle data_valid or error flags.
- Sits between the RX input synchroniser and the counter, sampler, checker and deserializer blocks.

Parameters:
PRESC_W, 6, width of prescale input.
EDGE_W, 5, width of edge_count input.
BIT_W, 4, width of bit_count input.

Ports:
clk  input  1  oversampling clock (prescale × baud).
rst  input  1  asynchronous, active-low reset.
rx_in  input  1  synchronised serial line, idle high.
par_en  input  1  parity enable configuration.
prescale  input  PRESC_W  oversample ratio; legal values 8, 16, 32.
edge_count  input  EDGE_W  current edge count from the counter.
bit_count  input  BIT_W  current bit index from the counter: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop.
done_edge  input  1  last edge of the current bit (edge_count == prescale-1).
strt_glitch  input  1  start checker result: sampled start bit was 1.
par_err  input  1  parity checker result.
stp_err  input  1  stop checker result: sampled stop bit was 0.
counter_enable  output  1  run the edge/bit counter.
counter_par_en  output  1  frame-latched parity enable sent to the counter.
samp_en  output  1  enable for the majority sampler.
strt_chk_en  output  1  start checker strobe.
deser_en  output  1  deserializer shift strobe.
par_chk_en  output  1  parity checker strobe.
stp_chk_en  output  1  stop checker strobe.
data_valid  output  1  one-cycle pulse: good frame.
par_error  output  1  sticky flag for the last frame.
stop_error  output  1  sticky flag for the last frame.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. State register is async-reset to IDLE.
- Sample point: sp = (prescale>>1) + 2, i.e. the cycle after the 3-tap majority sampler (taps p/2-1, p/2, p/2+1) has registered its result.
- Checker and deser strobes:
  - Combinational, high for exactly one cycle when edge_count == sp.
  - Qualified by state: START→strt_chk_en, DATA→deser_en, PARITY→par_chk_en, STOP→stp_chk_en.
  - Checker result inputs are registered and stable by done_edge of the same bit.
- IDLE:
  - counter_enable = ~rx_in (Mealy), so the falling-edge cycle counts as edge 0.
  - On rx_in==0: latch par_en into par_en_frm and go to START.
  - samp_en=0.
- START: at done_edge, strt_glitch=1 → IDLE (no data_valid, error flags unchanged); otherwise → DATA.
- DATA: at done_edge with bit_count==8 → PARITY if par_en_frm, else STOP.
- PARITY: at done_edge → STOP; par_err is captured into a frame error register.
- STOP, at done_edge:
  - Registered next cycle: par_error <= captured parity error; stop_error <= stp_err; data_valid <= ~(captured parity error | stp_err) for one cycle.
  - Next state: START if rx_in==0 (back-to-back frame; counter_enable stays 1 and par_en_frm is re-latched), else IDLE.
- In every state other than IDLE: counter_enable=1 and samp_en=1.
- counter_par_en = par_en_frm. A par_en change mid-frame has no effect until the next start.
- Counter wrap: the counter returns bit_count and edge_count to 0 on the final done_edge, so no explicit clear is needed. Leaving to IDLE deasserts counter_enable, which also clears bit_count.
- Reset values: state IDLE; par_en_frm 0; data_valid 0; par_error 0; stop_error 0; all strobes 0.
- Async reset mid-frame aborts immediately. Output is silent until a fresh falling edge after reset release.
- The captured parity error is cleared on entering START.
- Without parity, bit 9 is the stop bit; with parity, bit 10 is the stop bit.

Test Plan:
1. Prescale 8, par_en=0, send 0xA5 (LSB first), idle high after: deser_en pulses 8 times at edge 6; data_valid is high one cycle 1 clk after stop done_edge; both error flags 0; FSM returns to IDLE.
2. Prescale 16, par_en=1, send 0x3C with even parity bit 0: par_chk_en pulses once at edge 10 of bit 9; data_valid=1; par_error=0.
3. Prescale 8, 2-cycle low glitch on rx_in: strt_glitch=1 at start done_edge; FSM returns to IDLE; no deser_en, no data_valid; counter_enable=0 afterwards.
4. Prescale 8, par_en=1, wrong parity bit: par_error=1, data_valid stays 0. Then a stop bit of 0 in the next frame: stop_error=1.
5. Back-to-back frames, first with par_en=1 and second with par_en=0 (par_en toggled mid first frame): first frame uses 11 bits, second uses 10; counter_par_en changes only at the second start; two data_valid pulses; counter_enable never drops between frames.
6. Assert rst during DATA bit 4: all outputs go to 0 immediately; after release, rx_in held high gives no activity; a new frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_fsm.sv
// Receive-side sequencer for the UART RX path: tracks frame phase, strobes the
// start/data/parity/stop checkers and deserializer at mid-bit, and qualifies each frame.
module uart_rx_ctrl_fsm #(
  parameter int PRESC_W = 6,
  parameter int EDGE_W  = 5,
  parameter int BIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rx_in,
  input  logic               i_par_en,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic [EDGE_W-1:0]  i_edge_count,
  input  logic [BIT_W-1:0]   i_bit_count,
  input  logic               i_done_edge,
  input  logic               i_strt_glitch,
  input  logic               i_par_err,
  input  logic               i_stp_err,
  output logic               o_counter_enable,
  output logic               o_counter_par_en,
  output logic               o_samp_en,
  output logic               o_strt_chk_en,
  output logic               o_deser_en,
  output logic               o_par_chk_en,
  output logic               o_stp_chk_en,
  output logic               o_data_valid,
  output logic               o_par_error,
  output logic               o_stop_error
);

  localparam int CMP_W = (PRESC_W > EDGE_W) ? PRESC_W : EDGE_W;
  localparam logic [CMP_W-1:0] SP_OFFSET     = CMP_W'(2);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_par_en_frm;
  logic             r_par_err_cap;
  logic             r_data_valid;
  logic             r_par_error;
  logic             r_stop_error;
  logic             w_latch_par;
  logic             w_cap_clr;
  logic             w_cap_set;
  logic             w_frame_end;
  logic [CMP_W-1:0] w_sp;
  logic [CMP_W-1:0] w_edge;
  logic             w_at_sp;

  // Sample point sits one cycle after the 3-tap majority sampler registers its vote.
  assign w_sp    = CMP_W'(i_prescale[PRESC_W-1:1]) + SP_OFFSET;
  assign w_edge  = CMP_W'(i_edge_count);
  assign w_at_sp = (w_edge == w_sp);

  // Next-state decode plus counter/sampler/checker strobes
  always_comb begin
    w_state_nxt      = r_state;
    w_latch_par      = 1'b0;
    w_cap_clr        = 1'b0;
    w_cap_set        = 1'b0;
    w_frame_end      = 1'b0;
    o_counter_enable = 1'b1;
    o_samp_en        = 1'b1;
    o_strt_chk_en    = 1'b0;
    o_deser_en       = 1'b0;
    o_par_chk_en     = 1'b0;
    o_stp_chk_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_counter_enable = ~i_rx_in;
        o_samp_en        = 1'b0;
        if (!i_rx_in) begin
          w_state_nxt = S_START;
          w_latch_par = 1'b1;
          w_cap_clr   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        o_strt_chk_en = w_at_sp;
        if (i_done_edge) begin
          w_state_nxt = i_strt_glitch ? S_IDLE : S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        o_deser_en = w_at_sp;
        if (i_done_edge && (i_bit_count == LAST_DATA_BIT)) begin
          w_state_nxt = r_par_en_frm ? S_PARITY : S_STOP;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        o_par_chk_en = w_at_sp;
        if (i_done_edge) begin
          w_state_nxt = S_STOP;
          w_cap_set   = 1'b1;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        o_stp_chk_en = w_at_sp;
        if (i_done_edge) begin
          w_frame_end = 1'b1;
          // A line still low here is taken as the start bit of the next frame.
          if (!i_rx_in) begin
            w_state_nxt = S_START;
            w_latch_par = 1'b1;
            w_cap_clr   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        o_counter_enable = 1'b0;
        o_samp_en        = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-frame context: parity mode latched at start, parity result held until stop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_en_frm  <= 1'b0;
      r_par_err_cap <= 1'b0;
    end else begin
      if (w_latch_par) begin
        r_par_en_frm <= i_par_en;
      end
      if (w_cap_clr) begin
        r_par_err_cap <= 1'b0;
      end else if (w_cap_set) begin
        r_par_err_cap <= i_par_err;
      end
    end
  end

  // Frame verdict: one-cycle valid pulse and sticky error flags for the last frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_valid <= 1'b0;
      r_par_error  <= 1'b0;
      r_stop_error <= 1'b0;
    end else if (w_frame_end) begin
      r_data_valid <= ~(r_par_err_cap | i_stp_err);
      r_par_error  <= r_par_err_cap;
      r_stop_error <= i_stp_err;
    end else begin
      r_data_valid <= 1'b0;
    end
  end

  assign o_counter_par_en = r_par_en_frm;
  assign o_data_valid     = r_data_valid;
  assign o_par_error      = r_par_error;
  assign o_stop_error     = r_stop_error;

endmodule
